// File: rtl/mdl_hcomfsm_if.sv
// Host OOB line interface: detector levels and serial data in, differential line and status out.
// master = host COM FSM, slave = device side / line monitor.
interface mdl_hcomfsm_if;
  logic       i_cominit_det;
  logic       i_comwake_det;
  logic       i_tx;
  logic       o_tx_p;
  logic       o_tx_n;
  logic       o_idle;
  logic       o_link_up;
  logic [7:0] o_retries;

  modport master (
    input  i_cominit_det, i_comwake_det, i_tx,
    output o_tx_p, o_tx_n, o_idle, o_link_up, o_retries
  );

  modport slave (
    output i_cominit_det, i_comwake_det, i_tx,
    input  o_tx_p, o_tx_n, o_idle, o_link_up, o_retries
  );
endinterface

// File: rtl/mdl_hcomfsm.sv
// Host-side SATA OOB COM FSM: COMRESET/COMINIT/COMWAKE handshake, then serial pass-through.
// Optional wait-state timeout with retry is enabled by defining MDL_HCOM_TIMEOUT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RESET_HOLD  | one idle cycle before a fresh COMRESET sequence
// SEND_RESET  | NUM_COMRESET bursts, each followed by COMRESET_IDLE idle
// WAIT_INIT   | line idle, waiting for device COMINIT to rise then fall
// SEND_WAKE   | NUM_COMWAKE bursts, each followed by COMWAKE_IDLE idle
// WAIT_WAKE   | line idle, waiting for device COMWAKE to rise then fall
// ACTIVE      | link up, i_tx forwarded onto the pair
module mdl_hcomfsm #(
  parameter int NUM_COMRESET   = 6,
  parameter int NUM_COMWAKE    = 6,
  parameter int BURST_LEN      = 160,
  parameter int COMRESET_IDLE  = 480,
  parameter int COMWAKE_IDLE   = 160,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic           i_txclk,
  input logic           i_reset,
  mdl_hcomfsm_if.master bus
);

  localparam int NUM_MAX  = (NUM_COMRESET > NUM_COMWAKE) ? NUM_COMRESET : NUM_COMWAKE;
  localparam int IDLE_MAX = (COMRESET_IDLE > COMWAKE_IDLE) ? COMRESET_IDLE : COMWAKE_IDLE;
  localparam int BURST_W  = (NUM_MAX > 1) ? $clog2(NUM_MAX) : 1;
  localparam int SYM_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int IDLE_W   = (IDLE_MAX > 1) ? $clog2(IDLE_MAX) : 1;
  localparam int BIT_W    = 6;

  localparam logic [9:0]  D24_3      = 10'b1100110011;
  localparam logic [39:0] BURST_WORD = {D24_3, ~D24_3, D24_3, ~D24_3};

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_SEND_RESET = 3'd1,
    ST_WAIT_INIT  = 3'd2,
    ST_SEND_WAKE  = 3'd3,
    ST_WAIT_WAKE  = 3'd4,
    ST_ACTIVE     = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           ci_sync_q, ci_sync_d;
  logic [2:0]           cw_sync_q, cw_sync_d;
  logic                 ci_dly_q, ci_dly_d;
  logic                 seen_q, seen_d;
  logic                 in_gap_q, in_gap_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [SYM_W-1:0]     sym_q, sym_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic [39:0]          shift_q, shift_d;
  logic                 tx_p_q, tx_p_d;
  logic                 tx_n_q, tx_n_d;
  logic                 idle_q, idle_d;
  logic                 link_up_q, link_up_d;
  logic [7:0]           retries_q, retries_d;

  logic                 ci_s3, cw_s3, ci_rise;
  logic                 retry_inc, load_burst, clr_burst, enter_wait;
  logic [IDLE_W-1:0]    gap_last;
  logic [BURST_W-1:0]   num_last;

`ifdef MDL_HCOM_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMR_W-1:0]     timer_q, timer_d;
`endif

  assign ci_s3   = ci_sync_q[2];
  assign cw_s3   = cw_sync_q[2];
  assign ci_rise = ci_s3 & ~ci_dly_q;

  always_comb begin
    ci_sync_d  = {ci_sync_q[1:0], bus.i_cominit_det};
    cw_sync_d  = {cw_sync_q[1:0], bus.i_comwake_det};
    ci_dly_d   = ci_s3;
    state_d    = state_q;
    seen_d     = seen_q;
    in_gap_d   = in_gap_q;
    burst_d    = burst_q;
    sym_d      = sym_q;
    bit_d      = bit_q;
    idle_cnt_d = idle_cnt_q;
    shift_d    = shift_q;
    retry_inc  = 1'b0;
    load_burst = 1'b0;
    clr_burst  = 1'b0;
    enter_wait = 1'b0;

    if (state_q == ST_SEND_RESET) begin
      gap_last = IDLE_W'(COMRESET_IDLE - 1);
      num_last = BURST_W'(NUM_COMRESET - 1);
    end else begin
      gap_last = IDLE_W'(COMWAKE_IDLE - 1);
      num_last = BURST_W'(NUM_COMWAKE - 1);
    end

    case (state_q)
      ST_RESET_HOLD: begin
        state_d    = ST_SEND_RESET;
        clr_burst  = 1'b1;
        load_burst = 1'b1;
      end
      ST_SEND_RESET, ST_SEND_WAKE: begin
        // A COMINIT during our COMWAKE means the device restarted its side.
        if (state_q == ST_SEND_WAKE && ci_rise) begin
          clr_burst  = 1'b1;
          load_burst = 1'b1;
          retry_inc  = 1'b1;
        end else if (!in_gap_q) begin
          if (sym_q == '0) begin
            in_gap_d   = 1'b1;
            idle_cnt_d = gap_last;
          end else begin
            sym_d = sym_q - 1'b1;
            if (bit_q == '0) begin
              bit_d   = BIT_W'(39);
              shift_d = BURST_WORD;
            end else begin
              bit_d   = bit_q - 1'b1;
              shift_d = {shift_q[38:0], 1'b0};
            end
          end
        end else if (idle_cnt_q != '0) begin
          idle_cnt_d = idle_cnt_q - 1'b1;
        end else if (burst_q == num_last) begin
          state_d    = (state_q == ST_SEND_RESET) ? ST_WAIT_INIT : ST_WAIT_WAKE;
          enter_wait = 1'b1;
        end else begin
          burst_d    = burst_q + 1'b1;
          load_burst = 1'b1;
        end
      end
      ST_WAIT_INIT: begin
        seen_d = seen_q | ci_s3;
        if (seen_q && !ci_s3) begin
          state_d    = ST_SEND_WAKE;
          clr_burst  = 1'b1;
          load_burst = 1'b1;
        end
      end
      ST_WAIT_WAKE: begin
        if (ci_rise) begin
          state_d    = ST_WAIT_INIT;
          enter_wait = 1'b1;
          retry_inc  = 1'b1;
        end else begin
          seen_d = seen_q | cw_s3;
          if (seen_q && !cw_s3) state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (ci_rise) begin
          state_d    = ST_WAIT_INIT;
          enter_wait = 1'b1;
          retry_inc  = 1'b1;
        end
      end
      default: state_d = ST_RESET_HOLD;
    endcase

`ifdef MDL_HCOM_TIMEOUT_EN
    if ((state_q == ST_WAIT_INIT || state_q == ST_WAIT_WAKE) && state_d == state_q &&
        timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      state_d   = ST_RESET_HOLD;
      retry_inc = 1'b1;
    end
    if ((state_q == ST_WAIT_INIT || state_q == ST_WAIT_WAKE) && !enter_wait)
      timer_d = timer_q + 1'b1;
    else
      timer_d = '0;
`else
    // Without the timeout both wait states hold until the device responds.
`endif

    if (enter_wait) seen_d = 1'b0;
    if (clr_burst)  burst_d = '0;
    if (load_burst) begin
      in_gap_d = 1'b0;
      sym_d    = SYM_W'(BURST_LEN - 1);
      bit_d    = BIT_W'(39);
      shift_d  = BURST_WORD;
    end

    retries_d = (retry_inc && retries_q != 8'hFF) ? retries_q + 1'b1 : retries_q;

    // Line outputs follow the next state so they register alongside it.
    tx_p_d    = 1'b0;
    tx_n_d    = 1'b0;
    idle_d    = 1'b1;
    link_up_d = (state_d == ST_ACTIVE);
    if ((state_d == ST_SEND_RESET || state_d == ST_SEND_WAKE) && !in_gap_d) begin
      tx_p_d = shift_d[39];
      tx_n_d = ~shift_d[39];
      idle_d = 1'b0;
    end else if (state_d == ST_ACTIVE) begin
      tx_p_d = bus.i_tx;
      tx_n_d = ~bus.i_tx;
      idle_d = 1'b0;
    end
  end

  always_ff @(posedge i_txclk) begin
    if (i_reset) begin
      state_q    <= ST_RESET_HOLD;
      ci_sync_q  <= '0;
      cw_sync_q  <= '0;
      ci_dly_q   <= 1'b0;
      seen_q     <= 1'b0;
      in_gap_q   <= 1'b0;
      burst_q    <= '0;
      sym_q      <= '0;
      bit_q      <= '0;
      idle_cnt_q <= '0;
      shift_q    <= '0;
      tx_p_q     <= 1'b0;
      tx_n_q     <= 1'b0;
      idle_q     <= 1'b1;
      link_up_q  <= 1'b0;
      retries_q  <= '0;
`ifdef MDL_HCOM_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ci_sync_q  <= ci_sync_d;
      cw_sync_q  <= cw_sync_d;
      ci_dly_q   <= ci_dly_d;
      seen_q     <= seen_d;
      in_gap_q   <= in_gap_d;
      burst_q    <= burst_d;
      sym_q      <= sym_d;
      bit_q      <= bit_d;
      idle_cnt_q <= idle_cnt_d;
      shift_q    <= shift_d;
      tx_p_q     <= tx_p_d;
      tx_n_q     <= tx_n_d;
      idle_q     <= idle_d;
      link_up_q  <= link_up_d;
      retries_q  <= retries_d;
`ifdef MDL_HCOM_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign bus.o_tx_p    = tx_p_q;
  assign bus.o_tx_n    = tx_n_q;
  assign bus.o_idle    = idle_q;
  assign bus.o_link_up = link_up_q;
  assign bus.o_retries = retries_q;

endmodule

// File: doc/mdl_hcomfsm.md
Name: mdl_hcomfsm

Overview:
- Bench model of the host side of the SATA OOB handshake; the initiator end facing the device-side COM FSM model.
- Transmits COMRESET bursts, waits for the device COMINIT, then transmits COMWAKE and waits for the device COMWAKE.
- Once the handshake completes, it forwards serial data from i_tx onto the differential pair.
- Runs at symbol rate: one UI per i_txclk.

Parameters:
- NUM_COMRESET, 6: COMRESET bursts per attempt.
- NUM_COMWAKE, 6: COMWAKE bursts per attempt.
- BURST_LEN, 160: symbols per burst.
- COMRESET_IDLE, 480: idle cycles after each COMRESET burst (320 ns at 1.5 Gb/s).
- COMWAKE_IDLE, 160: idle cycles after each COMWAKE burst (106.7 ns).
- TIMEOUT_CYCLES, 65536: cycles spent in a wait state before a retry (only with the optional feature).

Ports:
- i_txclk  input  1  symbol clock.
- i_reset  input  1  synchronous, active-high reset.
- i_cominit_det  input  1  level; high while a device COMINIT burst train is detected.
- i_comwake_det  input  1  level; high while a device COMWAKE burst train is detected.
- i_tx  input  1  serial data to send once the link is up.
- o_tx_p  output  1  positive serial line.
- o_tx_n  output  1  negative serial line.
- o_idle  output  1  high while the transmitter is in electrical idle.
- o_link_up  output  1  high in ACTIVE.
- o_retries  output  8  saturating count of handshake restarts.

Behaviour:
- Reset values: state RESET_HOLD, o_idle=1, o_tx_p=o_tx_n=0, o_link_up=0, o_retries=0, burst/symbol/idle counters cleared.
- Reset behaviour: reset wins over every other event, including reset arriving mid-burst.
- Input synchronisers:
  - i_cominit_det and i_comwake_det each pass through a 3-flop pipe before use.
  - Every detector reaction therefore lags the input by 3 cycles plus 1 registered cycle.
- Burst pattern:
  - 40-bit word {D24.3, ~D24.3, D24.3, ~D24.3}, with D24.3 = 10'b1100110011, shifted out MSB first.
  - The word is reloaded every 40 symbols, so one 160-symbol burst = 4 words.
- Line drive:
  - During bursts and ACTIVE: o_tx_p = bit, o_tx_n = ~bit, o_idle = 0.
  - During idle gaps and wait states: o_tx_p = o_tx_n = 0, o_idle = 1.
- RESET_HOLD: held for one cycle, then go to SEND_RESET with burst counter 0.
- SEND_RESET:
  - Each burst: 160 symbol cycles, then COMRESET_IDLE idle cycles.
  - The burst counter increments at the end of each gap.
  - After gap NUM_COMRESET completes, go to WAIT_INIT.
- WAIT_INIT:
  - Line idle.
  - On the synchronised cominit rising edge, record that it was seen.
  - On its subsequent fall, go to SEND_WAKE.
  - A cominit already high on entry counts as seen.
- SEND_WAKE:
  - Same sequencing as SEND_RESET, using NUM_COMWAKE bursts and COMWAKE_IDLE gaps.
  - Then go to WAIT_WAKE.
  - A cominit that reasserts here returns the FSM to SEND_WAKE burst 0, since the device restarted.
- WAIT_WAKE:
  - Wait for the synchronised comwake to rise and then fall, then go to ACTIVE.
  - A cominit rise here returns the FSM to WAIT_INIT.
- ACTIVE:
  - o_link_up=1.
  - The line carries i_tx registered one cycle (o_tx_p = i_tx delayed by 1).
  - A cominit rise in ACTIVE (device reset) drops o_link_up on the next cycle and goes to WAIT_INIT.
- Retry counter: o_retries increments on every return to an earlier state, and saturates at 255.
- Counter widths: $clog2 of the maximum terminal value plus one.
- Illegal state: go to RESET_HOLD.

Optional Feature:
- Macro: MDL_HCOM_TIMEOUT_EN.
- Defined:
  - A timer clears on entry to WAIT_INIT or WAIT_WAKE and counts while in either state.
  - When it reaches TIMEOUT_CYCLES-1 with no completed detection, go to RESET_HOLD and increment o_retries.
- Undefined: both wait states wait indefinitely, and the timer logic is absent.

Test Plan:
- Reset release, no detector activity:
  - Exactly 6 bursts of 160 toggling symbols, starting with the pattern 1100110011; o_idle=0 during bursts.
  - 480-cycle idle gaps with o_tx_p=o_tx_n=0.
  - WAIT_INIT entered 3840 cycles after RESET_HOLD exit.
- Full handshake:
  - Pulse cominit 200 cycles after WAIT_INIT entry -> 6 COMWAKE bursts with 160-cycle gaps, starting 4 cycles after cominit falls.
  - Then pulse comwake -> o_link_up=1 4 cycles after comwake falls.
  - With i_tx = 0,1,1,0, o_tx_p follows 1 cycle later and o_tx_n is its inverse.
- Reset mid-burst: assert i_reset during COMRESET burst 3, symbol 70 -> next cycle o_idle=1, outputs 0, o_retries=0, then the sequence restarts from burst 0.
- Device re-init:
  - cominit in ACTIVE -> o_link_up=0, WAIT_INIT entered, o_retries=1.
  - Completing the handshake again -> o_link_up=1.
- With MDL_HCOM_TIMEOUT_EN and TIMEOUT_CYCLES=1000, no cominit -> COMRESET resent 1000 cycles after WAIT_INIT entry; o_retries counts 1, 2, 3 across successive attempts.
- Without the macro, same stimulus -> remains in WAIT_INIT for 100000 cycles, o_idle=1, o_retries=0.
